xmtr: RTL and testbench
=======================

// Module: xmtr
// PURPOSE
//  Serial word transmitter; the transmit end of the frame-sync/serial-data link whose receive end is rcvr.
//  Accepts parallel words over a valid/ready handshake, buffers them, emits one-cycle frame sync (o_fs) then MSB-first bits on o_d.
//  Sits on the controller side, driving the fs/d pair into a remote rcvr clocked from the same i_clk domain.
// PARAMETERS
//  DATA_W       16  word width; must equal the rcvr word width (16) for interoperability
//  FIFO_DEPTH   4   input buffer depth in words (power of 2, >=2); used only with XMTR_FIFO_EN
//  FRAME_WORDS  8   max contiguous words after one o_fs before o_fs is reissued for realignment (>=1)
// PORTS
//  i_clk     in   1       clock; all logic on posedge
//  i_rst_n   in   1       asynchronous active-low reset
//  i_data    in   DATA_W  word to send
//  i_vld     in   1       i_data valid
//  o_rdy     out  1       buffer can accept; a word transfers when i_vld & o_rdy at posedge
//  o_fs      out  1       frame sync, high exactly one cycle before the first MSB of a burst
//  o_d       out  1       serial data, MSB first, one bit per cycle
//  o_busy    out  1       high while in SYNC or SHIFT, or while the buffer is non-empty
// BEHAVIOUR
//  - Reset (async assert, sync release): state IDLE, buffer empty, o_fs=0, o_d=0, o_busy=0, o_rdy=1 after release.
//  - o_fs and o_d are registered outputs, with no combinational path from inputs.
//  - FSM states and transitions:
//    IDLE:  o_fs=0, o_d=0. If buffer non-empty -> SYNC.
//    SYNC:  o_fs=1, o_d=0 for one cycle; pop head word into shift reg; bit_cnt=0, word_cnt=0 -> SHIFT.
//    SHIFT: o_d=shift[DATA_W-1] and shift left each cycle; bit_cnt counts 0..DATA_W-1. At bit_cnt==DATA_W-1:
//           - if buffer non-empty and word_cnt<FRAME_WORDS-1: pop next word, word_cnt++, stay SHIFT with no gap and no o_fs;
//           - else if buffer non-empty: -> SYNC (o_fs reissued);
//           - else -> IDLE.
//  - Latency: word accepted at edge T into empty IDLE xmtr -> o_fs high in cycle T+1, MSB in T+2, LSB in T+DATA_W+1;
//    the remote rcvr asserts o_vld one cycle after the LSB.
//  - Continuous stream: consecutive words of one burst are back-to-back, exactly DATA_W cycles apart; this matches the rcvr counter wrap.
//  - Buffer full: o_rdy=0 and i_vld is ignored. Push and pop in the same cycle while full is allowed; o_rdy is computed from the pre-pop count.
//  - Empty buffer in SHIFT at the last bit: the current word completes intact, then IDLE. A word never truncates.
//  - Reset mid-word: outputs go to reset values immediately and the buffer is flushed. The next word is always preceded by o_fs.
//  - word_cnt is $clog2(FRAME_WORDS)+1 bits wide. bit_cnt is $clog2(DATA_W) bits wide, and its wrap is not used for control.
// CONFIGURATION
//  XMTR_FIFO_EN defined: input buffer is a FIFO of FIFO_DEPTH words (xmtr_fifo); o_rdy = !full.
//  XMTR_FIFO_EN undefined: single holding register; o_rdy = !hold_vld.
//    The register may be refilled in the same cycle it is popped only if o_rdy was already high; otherwise 1-cycle bubble.
//    FIFO_DEPTH is ignored.
//  FSM, serial timing and FRAME_WORDS behaviour are identical in both builds.
// STRUCTURE
//  Shared package: DATA_W default, FSM state encoding (IDLE/SYNC/SHIFT localparams).
//  Sub-module xmtr_fifo (sync FIFO: push/pop/full/empty/count, async active-low reset); instantiated only under XMTR_FIFO_EN.
//  Top holds FSM, shift register, bit_cnt, word_cnt and output registers.
// TESTING (loopback: xmtr o_fs/o_d -> rcvr i_fs/i_d, same i_clk)
//  1. Single word 16'hA5C3 into idle DUT -> o_fs one cycle, o_d = 1010_0101_1100_0011 next 16 cycles; rcvr o_data=16'hA5C3 with o_vld.
//  2. Words 16'h0001,16'h8000,16'hFFFF back-to-back, FRAME_WORDS=2 -> one o_fs, 32 contiguous bits, o_fs again, 16 bits; rcvr gets all 3 in order.
//  3. Hold i_vld with FIFO_DEPTH=4 while DUT is busy -> o_rdy drops after 4 buffered words; no word lost or duplicated; o_rdy recovers on the first pop.
//  4. Assert i_rst_n low at bit 7 of 16'h1234 -> o_fs=0, o_d=0, o_rdy=1 after release. Next word 16'hBEEF is preceded by o_fs and received intact.
//  5. Idle after last word -> o_d=0, o_fs=0, o_busy=0 within 1 cycle of the LSB; a new word gets a fresh o_fs.
//  6. Rebuild without XMTR_FIFO_EN; rerun tests 1-2 -> identical serial waveforms. Test 3 shows o_rdy low while the holding register is full.

Source files
------------

// File: rtl/xmtr_pkg.sv
// ----------------------------------------------------------------------------
// xmtr_pkg
//   Shared definitions for the serial word transmitter (xmtr) and its input
//   buffer.
//   - DATA_W_DEF : default word width. It must match the word width of the
//                  remote rcvr.
//   - xmtr_state_e : FSM state encoding (IDLE / SYNC / SHIFT).
//   - cnt_width()  : width helper that never returns zero.
//   Build option: XMTR_FIFO_EN selects the FIFO input buffer in xmtr.
// ----------------------------------------------------------------------------
package xmtr_pkg;

  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_SHIFT = 2'd2
  } xmtr_state_e;

  // Number of bits needed to index n items. A single item still needs one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/xmtr_fifo.sv
// ----------------------------------------------------------------------------
// xmtr_fifo
//   Synchronous FIFO used as the xmtr input buffer when XMTR_FIFO_EN is
//   defined. It holds DEPTH words of W bits.
//   The head word is always visible on rdata, so a pop consumes the word that
//   the consumer has already read.
//   Ports:
//     i_clk    in   1         clock, posedge
//     i_rst_n  in   1         asynchronous active-low reset (flushes the FIFO)
//     push     in   1         write wdata (ignored when full)
//     pop      in   1         drop the head word (ignored when empty)
//     wdata    in   W         word to write
//     rdata    out  W         head word
//     full     out  1         DEPTH words stored
//     empty    out  1         no words stored
//     count    out  AW+1      number of stored words
// ----------------------------------------------------------------------------
module xmtr_fifo
  import xmtr_pkg::*;
#(
  parameter int W     = DATA_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        push,
  input  logic                        pop,
  input  logic [W-1:0]                wdata,
  output logic [W-1:0]                rdata,
  output logic                        full,
  output logic                        empty,
  output logic [cnt_width(DEPTH):0]   count
);

  localparam int AW = cnt_width(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  // Requests that would overflow or underflow are dropped here. This lets the
  // user logic pulse push/pop without re-checking the flags.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);
  assign count = cnt;
  assign rdata = mem[rd_ptr];

  // Pointer and occupancy bookkeeping. DEPTH is a power of two, so the
  // pointers wrap naturally. A simultaneous push and pop leaves the count
  // unchanged.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage array. It has no reset: the entries are only read when the count
  // says they hold valid data.
  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/xmtr.sv
// ----------------------------------------------------------------------------
// xmtr
//   Serial word transmitter, the transmit end of the fs/d link to rcvr.
//   Parallel words arrive over a valid/ready handshake and are buffered.
//   Each burst begins with a one-cycle frame sync (o_fs). The words then go
//   out MSB first on o_d, back to back. o_fs is reissued after FRAME_WORDS
//   contiguous words so that the receiver can realign.
//   Ports:
//     i_clk    in   1       clock, posedge
//     i_rst_n  in   1       asynchronous active-low reset
//     i_data   in   DATA_W  word to send
//     i_vld    in   1       i_data valid
//     o_rdy    out  1       buffer can accept (transfer on i_vld & o_rdy)
//     o_fs     out  1       frame sync, one cycle before the first MSB
//     o_d      out  1       serial data, MSB first
//     o_busy   out  1       sync/shift in progress or buffer non-empty
//   Build option:
//     XMTR_FIFO_EN defined   : FIFO_DEPTH-word FIFO buffer (xmtr_fifo)
//     XMTR_FIFO_EN undefined : single holding register, FIFO_DEPTH unused
// ----------------------------------------------------------------------------
module xmtr
  import xmtr_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int FIFO_DEPTH  = 4,
  parameter int FRAME_WORDS = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_vld,
  output logic              o_rdy,
  output logic              o_fs,
  output logic              o_d,
  output logic              o_busy
);

  localparam int BIT_W = cnt_width(DATA_W);
  localparam int WC_W  = $clog2(FRAME_WORDS) + 1;
  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(DATA_W - 1);
  localparam logic [WC_W-1:0]  LAST_WORD  = WC_W'(FRAME_WORDS - 1);

  xmtr_state_e       state;
  xmtr_state_e       state_next;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_next;
  logic [BIT_W-1:0]  bit_cnt;
  logic [BIT_W-1:0]  bit_cnt_next;
  logic [WC_W-1:0]   word_cnt;
  logic [WC_W-1:0]   word_cnt_next;
  logic              fs_next;
  logic              d_next;
  logic              last_bit;
  logic              frame_room;

  logic              push;
  logic              buf_pop;
  logic              buf_empty;
  logic [DATA_W-1:0] buf_head;

  // A word transfers on any edge where the buffer offered space. o_rdy comes
  // only from the buffer state before the edge, so a pop in the same cycle
  // does not open a slot early.
  assign push = i_vld && o_rdy;

`ifdef XMTR_FIFO_EN
  logic                           buf_full;
  logic [cnt_width(FIFO_DEPTH):0] unused_buf_count;

  // Multi-word input buffer. Producers can run ahead of the serial line by
  // FIFO_DEPTH words.
  xmtr_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .push    (push),
    .pop     (buf_pop),
    .wdata   (i_data),
    .rdata   (buf_head),
    .full    (buf_full),
    .empty   (buf_empty),
    .count   (unused_buf_count)
  );

  assign o_rdy = !buf_full;
`else
  logic              hold_vld;
  logic [DATA_W-1:0] hold_data;
  logic              unused_fifo_depth;

  // Single holding register. o_rdy is low while it is occupied, so a push
  // can never coincide with the pop that empties it. Refilling therefore
  // costs a one-cycle bubble.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hold_vld  <= 1'b0;
      hold_data <= '0;
    end else if (push) begin
      hold_vld  <= 1'b1;
      hold_data <= i_data;
    end else if (buf_pop) begin
      hold_vld  <= 1'b0;
    end
  end

  assign buf_empty         = !hold_vld;
  assign buf_head          = hold_data;
  assign o_rdy             = !hold_vld;
  assign unused_fifo_depth = (FIFO_DEPTH > 0);
`endif

  assign last_bit   = (bit_cnt == LAST_BIT);
  assign frame_room = (word_cnt < LAST_WORD);
  assign o_busy     = (state != ST_IDLE) || !buf_empty;

  // Next-state, shifter and buffer-pop decisions.
  // SYNC always pops, because it is only entered with a non-empty buffer.
  // At the last bit of a word, SHIFT either chains the next word without a
  // gap, returns to SYNC to reissue o_fs, or falls back to IDLE. The
  // current word always finishes first.
  always_comb begin
    state_next    = state;
    shift_next    = shift_q;
    bit_cnt_next  = bit_cnt;
    word_cnt_next = word_cnt;
    buf_pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!buf_empty) begin
          state_next = ST_SYNC;
        end
      end
      ST_SYNC: begin
        buf_pop       = 1'b1;
        shift_next    = buf_head;
        bit_cnt_next  = '0;
        word_cnt_next = '0;
        state_next    = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (!last_bit) begin
          shift_next   = shift_q << 1;
          bit_cnt_next = bit_cnt + BIT_W'(1);
        end else if (!buf_empty && frame_room) begin
          buf_pop       = 1'b1;
          shift_next    = buf_head;
          bit_cnt_next  = '0;
          word_cnt_next = word_cnt + WC_W'(1);
        end else if (!buf_empty) begin
          state_next = ST_SYNC;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // The output flops are loaded with the value that belongs to the upcoming
  // state, so o_fs and o_d line up with that state. In SHIFT the shifter
  // MSB is the bit on the line. Outside SHIFT the line is held low.
  assign fs_next = (state_next == ST_SYNC);
  assign d_next  = (state_next == ST_SHIFT) && shift_next[DATA_W-1];

  // State, datapath and registered outputs. An asynchronous reset drops the
  // line immediately, so a frame cut short is never completed.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      shift_q  <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
      o_fs     <= 1'b0;
      o_d      <= 1'b0;
    end else begin
      state    <= state_next;
      shift_q  <= shift_next;
      bit_cnt  <= bit_cnt_next;
      word_cnt <= word_cnt_next;
      o_fs     <= fs_next;
      o_d      <= d_next;
    end
  end

endmodule

// File: tb/tb_xmtr.sv
// ----------------------------------------------------------------------------
// tb_xmtr
//   Self-checking bench for xmtr. It runs with or without XMTR_FIFO_EN.
//   Stimulus tasks push words through the handshake. A negedge monitor holds
//   a reference model of the serial link: a queue of accepted words plus the
//   expected line activity. Every cycle it checks o_fs, o_d, o_busy and
//   o_rdy against that model, and it decodes each received word as the
//   remote rcvr would.
// ----------------------------------------------------------------------------
module tb_xmtr;

  localparam int DW = 16;
  localparam int FD = 4;
  localparam int FW = 2;
`ifdef XMTR_FIFO_EN
  localparam int CAP = FD;
`else
  localparam int CAP = 1;
`endif

  logic          i_clk;
  logic          i_rst_n;
  logic [DW-1:0] i_data;
  logic          i_vld;
  logic          o_rdy;
  logic          o_fs;
  logic          o_d;
  logic          o_busy;

  int checks;
  int failures;
  int cyc;

  // Reference model of the link
  logic [DW-1:0] pend_q[$];
  int            phase;
  logic [DW-1:0] cur_word;
  logic [DW-1:0] rx_bits;
  int            bit_idx;
  int            words_in_frame;
  bit            saw_rdy_low;

  xmtr #(
    .DATA_W      (DW),
    .FIFO_DEPTH  (FD),
    .FRAME_WORDS (FW)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_data  (i_data),
    .i_vld   (i_vld),
    .o_rdy   (o_rdy),
    .o_fs    (o_fs),
    .o_d     (o_d),
    .o_busy  (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Compare one observed value with the expected one and count it
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Line monitor and scoreboard. Phase 0: line idle. Phase 1: sync cycle
  // due. Phase 2: data bits of cur_word. Pops follow the rules: chain
  // without a gap while the frame has room, otherwise resync or go idle.
  always @(negedge i_clk) begin : monitor
    int occ;
    cyc++;
    if (!i_rst_n) begin
      checkOutput("reset_fs", o_fs, 0);
      checkOutput("reset_d", o_d, 0);
      checkOutput("reset_busy", o_busy, 0);
      checkOutput("reset_rdy", o_rdy, 1);
      pend_q.delete();
      phase = 0;
    end else begin
      occ = pend_q.size();
      checkOutput("rdy", o_rdy, occ < CAP);
      if (!o_rdy) saw_rdy_low = 1'b1;
      case (phase)
        0: begin
          checkOutput("idle_fs", o_fs, 0);
          checkOutput("idle_d", o_d, 0);
          checkOutput("idle_busy", o_busy, occ > 0);
          if (occ > 0) phase = 1;
        end
        1: begin
          checkOutput("sync_fs", o_fs, 1);
          checkOutput("sync_d", o_d, 0);
          checkOutput("sync_busy", o_busy, 1);
          cur_word = pend_q.pop_front();
          bit_idx = 0;
          words_in_frame = 1;
          rx_bits = '0;
          phase = 2;
        end
        default: begin
          checkOutput("data_fs", o_fs, 0);
          checkOutput("data_bit", o_d, cur_word[DW-1-bit_idx]);
          checkOutput("data_busy", o_busy, 1);
          rx_bits = {rx_bits[DW-2:0], o_d};
          if (bit_idx == DW-1) begin
            checkOutput("rx_word", rx_bits, cur_word);
            if (occ > 0 && words_in_frame < FW) begin
              cur_word = pend_q.pop_front();
              bit_idx = 0;
              words_in_frame++;
            end else if (occ > 0) begin
              phase = 1;
            end else begin
              phase = 0;
            end
          end else begin
            bit_idx++;
          end
        end
      endcase
      if (i_vld && o_rdy) pend_q.push_back(i_data);
    end
  end

  // Offer one word and hold it until the DUT takes it (bounded)
  task automatic applyStimulus(input logic [DW-1:0] w);
    bit accepted;
    accepted = 1'b0;
    i_data = w;
    i_vld = 1'b1;
    for (int n = 0; n < 200 && !accepted; n++) begin
      @(negedge i_clk);
      accepted = o_rdy;
      @(posedge i_clk);
      #1;
    end
    checkOutput("send_accept", accepted, 1);
  endtask

  task automatic idleCycles(input int n);
    i_vld = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic applyReset(input int n);
    i_vld = 1'b0;
    i_rst_n = 1'b0;
    for (int k = 0; k < n; k++) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
  endtask

  // Wait (bounded) until the transmitter reports idle with nothing pending
  task automatic waitDrain();
    bit done;
    done = 1'b0;
    i_vld = 1'b0;
    for (int n = 0; n < 2000 && !done; n++) begin
      @(posedge i_clk);
      #1;
      done = !o_busy && (pend_q.size() == 0);
    end
    checkOutput("drain", done, 1);
    idleCycles(3);
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    bit got_fs;
    checks = 0;
    failures = 0;
    cyc = 0;
    phase = 0;
    bit_idx = 0;
    words_in_frame = 0;
    cur_word = '0;
    rx_bits = '0;
    saw_rdy_low = 1'b0;
    i_data = '0;
    i_vld = 1'b0;
    i_rst_n = 1'b0;
    applyReset(3);
    idleCycles(2);

    $display("[TB] single word A5C3");
    applyStimulus(16'hA5C3);
    waitDrain();

    $display("[TB] burst 0001 8000 FFFF");
    applyStimulus(16'h0001);
    applyStimulus(16'h8000);
    applyStimulus(16'hFFFF);
    waitDrain();

    $display("[TB] back-pressure burst");
    saw_rdy_low = 1'b0;
    for (int k = 0; k < 8; k++) applyStimulus(16'h1100 + 16'(k));
    checkOutput("rdy_dropped", saw_rdy_low, 1);
    waitDrain();

    $display("[TB] reset mid-word");
    applyStimulus(16'h1234);
    i_vld = 1'b0;
    got_fs = 1'b0;
    for (int n = 0; n < 50 && !got_fs; n++) begin
      @(negedge i_clk);
      got_fs = o_fs;
    end
    checkOutput("fs_seen", got_fs, 1);
    repeat (8) @(posedge i_clk);
    #1;
    applyReset(2);
    idleCycles(2);
    applyStimulus(16'hBEEF);
    waitDrain();

    $display("[TB] randomized traffic");
    for (int k = 0; k < 40; k++) begin
      applyStimulus(16'($urandom));
      if ($urandom_range(0, 2) != 0) idleCycles($urandom_range(0, 24));
    end
    waitDrain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
